// File: rtl/regfile_sb.sv
// Parametrised register file: two combinational read ports with write bypass,
// main and link write ports, and a per-register busy scoreboard for RAW hazards.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 15,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              link_we,
  input  logic [DATA_W-1:0] link_wd,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              haz1,
  output logic              haz2,
  output logic [NREG-1:0]   busy_vec
);

  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  logic main_drop;
  logic main_acc;
  logic link_acc;
  logic hit1;
  logic hit2;

  // Main-port bypass stays enabled on a link collision; the link term has
  // higher read priority, so only the stored write has to be suppressed.
  assign main_drop = ZERO_REG && (wa == '0);
  assign link_acc  = link_we && !(ZERO_REG && (LINK_A == '0));
  assign main_acc  = we && !main_drop && !(link_acc && (wa == LINK_A));

  assign hit1 = (link_acc && (ra1 == LINK_A)) || (we && !main_drop && (ra1 == wa));
  assign hit2 = (link_acc && (ra2 == LINK_A)) || (we && !main_drop && (ra2 == wa));

  always_comb begin
    rd1 = regs_q[ra1];
    if (ZERO_REG && (ra1 == '0)) begin
      rd1 = '0;
    end else if (link_acc && (ra1 == LINK_A)) begin
      rd1 = link_wd;
    end else if (we && !main_drop && (ra1 == wa)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs_q[ra2];
    if (ZERO_REG && (ra2 == '0)) begin
      rd2 = '0;
    end else if (link_acc && (ra2 == LINK_A)) begin
      rd2 = link_wd;
    end else if (we && !main_drop && (ra2 == wa)) begin
      rd2 = wd;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (main_acc && (wa == ADDR_W'(i))) begin
        regs_d[i] = wd;
      end
      if (link_acc && (i == LINK_REG)) begin
        regs_d[i] = link_wd;
      end
    end
  end

  // Set is applied after clears so a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (main_acc) begin
      busy_d[wa] = 1'b0;
    end
    if (link_acc) begin
      busy_d[LINK_A] = 1'b0;
    end
    if (busy_set) begin
      busy_d[busy_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  assign haz1     = busy_q[ra1] & ~hit1;
  assign haz2     = busy_q[ra2] & ~hit2;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: vector table for bypass/collision/scoreboard
// behaviour, plus a hand-written mid-run reset sequence.
module tb_regfile_sb;

  logic        CLOCK;
  logic        RESET_N;
  logic [4:0]  ra1, ra2, wa, busy_addr;
  logic [31:0] rd1, rd2, wd, link_wd;
  logic        we, link_we, busy_set;
  logic        haz1, haz2;
  logic [31:0] busy_vec;

  int n_cmp;
  int n_bad;

  regfile_sb #(
    .DATA_W  (32),
    .NREG    (32),
    .ADDR_W  (5),
    .LINK_REG(15),
    .ZERO_REG(1'b1)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .link_we  (link_we),
    .link_wd  (link_wd),
    .busy_set (busy_set),
    .busy_addr(busy_addr),
    .haz1     (haz1),
    .haz2     (haz2),
    .busy_vec (busy_vec)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        link_we;
    logic [31:0] link_wd;
    logic        bset;
    logic [4:0]  baddr;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_haz1;
    logic        e_haz2;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [4:0] r1, input logic [4:0] r2,
    input logic w, input logic [4:0] a, input logic [31:0] d,
    input logic lw, input logic [31:0] ld,
    input logic bs, input logic [4:0] ba,
    input logic [31:0] x1, input logic [31:0] x2,
    input logic h1, input logic h2, input logic [31:0] bv);
    vec_t v;
    v.ra1 = r1; v.ra2 = r2; v.we = w; v.wa = a; v.wd = d;
    v.link_we = lw; v.link_wd = ld; v.bset = bs; v.baddr = ba;
    v.e_rd1 = x1; v.e_rd2 = x2; v.e_haz1 = h1; v.e_haz2 = h2; v.e_busy = bv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ra1 = '0; ra2 = '0; we = 1'b0; wa = '0; wd = '0;
    link_we = 1'b0; link_wd = '0; busy_set = 1'b0; busy_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive_idle();
    RESET_N = 1'b0;

    //        ra1 ra2 we wa  wd            lw lwd           bs ba  rd1           rd2           h1 h2 busy
    vecs.push_back(mk(0,  1, 0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(3,  7, 1, 7,  32'h12345678, 0, 32'h0,        1, 9,  32'h0,        32'h12345678, 0, 0, 32'h0));
    vecs.push_back(mk(7,  9, 0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h12345678, 32'h0,        0, 1, 32'h200));
    vecs.push_back(mk(9,  7, 1, 9,  32'hAAAA0009, 0, 32'h0,        0, 0,  32'hAAAA0009, 32'h12345678, 0, 0, 32'h200));
    vecs.push_back(mk(9,  0, 1, 0,  32'hFFFFFFFF, 0, 32'h0,        1, 0,  32'hAAAA0009, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0,  9, 0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h0,        32'hAAAA0009, 0, 0, 32'h0));
    vecs.push_back(mk(15, 15,1, 15, 32'hDEADBEEF, 1, 32'h40,       0, 0,  32'h40,       32'h40,       0, 0, 32'h0));
    vecs.push_back(mk(15, 7, 0, 0,  32'h0,        0, 32'h0,        1, 15, 32'h40,       32'h12345678, 0, 0, 32'h0));
    vecs.push_back(mk(15, 15,0, 0,  32'h0,        1, 32'h44,       0, 0,  32'h44,       32'h44,       0, 0, 32'h8000));
    vecs.push_back(mk(15, 9, 1, 9,  32'h99,       0, 32'h0,        1, 9,  32'h44,       32'h99,       0, 0, 32'h0));
    vecs.push_back(mk(9,  3, 0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h99,       32'h0,        1, 0, 32'h200));
    vecs.push_back(mk(9,  3, 0, 0,  32'h0,        0, 32'h0,        1, 9,  32'h99,       32'h0,        1, 0, 32'h200));
    vecs.push_back(mk(9,  3, 0, 0,  32'h0,        0, 32'h0,        1, 3,  32'h99,       32'h0,        1, 0, 32'h200));
    vecs.push_back(mk(15, 3, 1, 15, 32'h1515,     0, 32'h0,        0, 0,  32'h1515,     32'h0,        0, 1, 32'h208));
    vecs.push_back(mk(15, 7, 0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h1515,     32'h12345678, 0, 0, 32'h208));

    repeat (2) @(negedge CLOCK);
    #2;
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_rd1", rd1, 32'h0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLOCK);
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      link_we = vecs[i].link_we; link_wd = vecs[i].link_wd;
      busy_set = vecs[i].bset; busy_addr = vecs[i].baddr;
      #2;
      chk($sformatf("v%0d_rd1", i), rd1, vecs[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd2, vecs[i].e_rd2);
      chk($sformatf("v%0d_haz1", i), {31'b0, haz1}, {31'b0, vecs[i].e_haz1});
      chk($sformatf("v%0d_haz2", i), {31'b0, haz2}, {31'b0, vecs[i].e_haz2});
      chk($sformatf("v%0d_busy", i), busy_vec, vecs[i].e_busy);
    end

    // Asynchronous reset asserted mid-cycle with busy bits 3 and 9 pending.
    @(negedge CLOCK);
    drive_idle();
    ra1 = 5'd9; ra2 = 5'd3;
    #2;
    chk("pre_reset_haz1", {31'b0, haz1}, 32'h1);
    RESET_N = 1'b0;
    #1;
    chk("async_busy", busy_vec, 32'h0);
    chk("async_haz1", {31'b0, haz1}, 32'h0);
    chk("async_haz2", {31'b0, haz2}, 32'h0);
    chk("async_rd1", rd1, 32'h0);

    for (int i = 0; i < 32; i++) begin
      @(negedge CLOCK);
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #2;
      chk($sformatf("rst_rd1_r%0d", i), rd1, 32'h0);
      chk($sformatf("rst_rd2_r%0d", 31 - i), rd2, 32'h0);
    end

    @(negedge CLOCK);
    we = 1'b1; wa = 5'd5; wd = 32'h55; ra1 = 5'd5;
    link_we = 1'b1; link_wd = 32'h66; ra2 = 5'd15;
    busy_set = 1'b1; busy_addr = 5'd5;
    #2;
    chk("rst_bypass_rd1", rd1, 32'h55);
    chk("rst_bypass_rd2", rd2, 32'h66);
    chk("rst_hold_busy", busy_vec, 32'h0);

    @(negedge CLOCK);
    drive_idle();
    RESET_N = 1'b1;
    ra1 = 5'd5; ra2 = 5'd15;
    #2;
    chk("post_rst_rd1", rd1, 32'h0);
    chk("post_rst_rd2", rd2, 32'h0);
    chk("post_rst_busy", busy_vec, 32'h0);

    @(negedge CLOCK);
    ra1 = 5'd7; ra2 = 5'd9;
    #2;
    chk("post_rst_r7", rd1, 32'h0);
    chk("post_rst_r9", rd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
